// File: rtl/bht_write_scheduler.sv
// BHT write-port scheduler. It clears the table with a sweep after reset, then
// serves ID allocations first and EXE counter updates through a small coalescing queue.
module bht_write_scheduler #(
    parameter int IDX_W  = 6,
    parameter int DATA_W = 20,
    parameter int QDEPTH = 2
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              en,
    input  logic              id_req,
    input  logic [IDX_W-1:0]  id_idx,
    input  logic [DATA_W-1:0] id_data,
    output logic              id_ack,
    input  logic              exe_req,
    input  logic [IDX_W-1:0]  exe_idx,
    input  logic [DATA_W-1:0] exe_data,
    output logic              bht_we,
    output logic [IDX_W-1:0]  bht_waddr,
    output logic [DATA_W-1:0] bht_wdata,
    output logic              init_busy,
    output logic              exe_full,
    output logic [7:0]        drop_cnt
);
    localparam int CNT_W = $clog2(QDEPTH + 1);
    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    typedef enum logic {INIT, RUN} state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  sweep_q, sweep_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  qIdx_q  [QDEPTH];
    logic [IDX_W-1:0]  qIdx_d  [QDEPTH];
    logic [DATA_W-1:0] qData_q [QDEPTH];
    logic [DATA_W-1:0] qData_d [QDEPTH];
    logic [7:0]        drop_q, drop_d;

    logic              pop;
    logic              direct;
    logic              exeLive;
    int                keep;
    logic [PTR_W-1:0]  tailPtr;

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= INIT;
            sweep_q <= '0;
            cnt_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    // Queue payload needs no reset; the count alone decides which slots are live.
    always_ff @(posedge CLK) begin
        qIdx_q  <= qIdx_d;
        qData_q <= qData_d;
    end

    always_comb begin
        state_d   = state_q;
        sweep_d   = sweep_q;
        cnt_d     = cnt_q;
        qIdx_d    = qIdx_q;
        qData_d   = qData_q;
        drop_d    = drop_q;
        bht_we    = 1'b0;
        bht_waddr = '0;
        bht_wdata = '0;
        id_ack    = 1'b0;
        pop       = 1'b0;
        direct    = 1'b0;
        exeLive   = 1'b0;
        keep      = 0;
        tailPtr   = '0;

        if (!rst && en) begin
            if (state_q == INIT) begin
                bht_we    = 1'b1;
                bht_waddr = sweep_q;
                sweep_d   = sweep_q + IDX_W'(1);
                if (sweep_q == '1) begin
                    state_d = RUN;
                end
            end else begin
                pop    = !id_req && (cnt_q != '0);
                direct = !id_req && (cnt_q == '0) && exe_req;
                if (id_req) begin
                    bht_we    = 1'b1;
                    bht_waddr = id_idx;
                    bht_wdata = id_data;
                    id_ack    = 1'b1;
                end else if (pop) begin
                    bht_we    = 1'b1;
                    bht_waddr = qIdx_q[0];
                    bht_wdata = qData_q[0];
                end else if (direct) begin
                    bht_we    = 1'b1;
                    bht_waddr = exe_idx;
                    bht_wdata = exe_data;
                end

                // Compact survivors to the front: drop the popped head and any
                // entry superseded by this cycle's ID allocation.
                for (int i = 0; i < QDEPTH; i++) begin
                    if ((i < int'(cnt_q)) && !(pop && (i == 0)) &&
                        !(id_req && (qIdx_q[i] == id_idx))) begin
                        qIdx_d[PTR_W'(keep)]  = qIdx_q[i];
                        qData_d[PTR_W'(keep)] = qData_q[i];
                        keep = keep + 1;
                    end
                end

                exeLive = exe_req && !direct && !(id_req && (exe_idx == id_idx));
                tailPtr = PTR_W'(keep - 1);
                if (exeLive) begin
                    if ((keep > 0) && (qIdx_d[tailPtr] == exe_idx)) begin
                        qData_d[tailPtr] = exe_data;
                    end else if (keep < QDEPTH) begin
                        qIdx_d[PTR_W'(keep)]  = exe_idx;
                        qData_d[PTR_W'(keep)] = exe_data;
                        keep = keep + 1;
                    end else if (drop_q != 8'hFF) begin
                        drop_d = drop_q + 8'd1;
                    end
                end
                cnt_d = CNT_W'(keep);
            end
        end
    end

    assign init_busy = rst || (state_q == INIT);
    assign exe_full  = !rst && (cnt_q == CNT_W'(QDEPTH));
    assign drop_cnt  = rst ? 8'd0 : drop_q;

endmodule

// File: tb/tb_bht_write_scheduler.sv
// Directed bench for bht_write_scheduler: a queue-based reference model checked
// every cycle, plus hand-computed spot checks along the directed sequence.
module tb_bht_write_scheduler;
    localparam int QDEPTH = 2;

    logic        CLK;
    logic        rst;
    logic        en;
    logic        id_req;
    logic [5:0]  id_idx;
    logic [19:0] id_data;
    logic        id_ack;
    logic        exe_req;
    logic [5:0]  exe_idx;
    logic [19:0] exe_data;
    logic        bht_we;
    logic [5:0]  bht_waddr;
    logic [19:0] bht_wdata;
    logic        init_busy;
    logic        exe_full;
    logic [7:0]  drop_cnt;

    int testCount = 0;
    int failCount = 0;
    int okCnt;

    typedef struct packed {
        logic [5:0]  idx;
        logic [19:0] data;
    } entry_t;

    entry_t      mQ[$];
    entry_t      newE;
    bit          mInit = 1'b1;
    int          mSweep = 0;
    int          mDrop = 0;
    logic        expWe;
    logic [5:0]  expAddr;
    logic [19:0] expData;
    logic        expAck;
    logic        expBusy;
    logic        expFull;
    logic [7:0]  expDrop;
    bit          direct;

    bht_write_scheduler #(.IDX_W(6), .DATA_W(20), .QDEPTH(QDEPTH)) dut (
        .CLK(CLK), .rst(rst), .en(en),
        .id_req(id_req), .id_idx(id_idx), .id_data(id_data), .id_ack(id_ack),
        .exe_req(exe_req), .exe_idx(exe_idx), .exe_data(exe_data),
        .bht_we(bht_we), .bht_waddr(bht_waddr), .bht_wdata(bht_wdata),
        .init_busy(init_busy), .exe_full(exe_full), .drop_cnt(drop_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; returns at the falling edge.
    task automatic applyStimulus(input logic r, input logic e, input logic ir,
                                 input logic [5:0] ii, input logic [19:0] id,
                                 input logic er, input logic [5:0] ei, input logic [19:0] ed);
        @(posedge CLK);
        #1;
        rst = r; en = e; id_req = ir; id_idx = ii; id_data = id;
        exe_req = er; exe_idx = ei; exe_data = ed;
        @(negedge CLK);
    endtask

    // Reference model: evaluate expected outputs, compare, then advance the model.
    always @(negedge CLK) begin
        expWe = 1'b0; expAddr = '0; expData = '0; expAck = 1'b0;
        direct = 1'b0;
        if (rst) begin
            expBusy = 1'b1; expFull = 1'b0; expDrop = 8'd0;
            mInit = 1'b1; mSweep = 0; mDrop = 0; mQ.delete();
        end else begin
            expBusy = mInit;
            expFull = (mQ.size() == QDEPTH);
            expDrop = 8'(mDrop);
            if (en && mInit) begin
                expWe = 1'b1; expAddr = mSweep[5:0]; expData = '0;
                mSweep++;
                if (mSweep == 64) begin
                    mInit = 1'b0;
                    mSweep = 0;
                end
            end else if (en) begin
                if (id_req) begin
                    expWe = 1'b1; expAddr = id_idx; expData = id_data; expAck = 1'b1;
                    for (int i = mQ.size() - 1; i >= 0; i--) begin
                        if (mQ[i].idx == id_idx) mQ.delete(i);
                    end
                end else if (mQ.size() > 0) begin
                    expWe = 1'b1; expAddr = mQ[0].idx; expData = mQ[0].data;
                    void'(mQ.pop_front());
                end else if (exe_req) begin
                    expWe = 1'b1; expAddr = exe_idx; expData = exe_data;
                    direct = 1'b1;
                end
                if (exe_req && !direct && !(id_req && exe_idx == id_idx)) begin
                    newE.idx = exe_idx;
                    newE.data = exe_data;
                    if (mQ.size() > 0 && mQ[mQ.size() - 1].idx == exe_idx) begin
                        void'(mQ.pop_back());
                        mQ.push_back(newE);
                    end else if (mQ.size() < QDEPTH) begin
                        mQ.push_back(newE);
                    end else if (mDrop < 255) begin
                        mDrop++;
                    end
                end
            end
        end
        checkOutput("bht_we", 32'(bht_we), 32'(expWe));
        checkOutput("id_ack", 32'(id_ack), 32'(expAck));
        checkOutput("init_busy", 32'(init_busy), 32'(expBusy));
        checkOutput("exe_full", 32'(exe_full), 32'(expFull));
        checkOutput("drop_cnt", 32'(drop_cnt), 32'(expDrop));
        if (expWe || rst) begin
            checkOutput("bht_waddr", 32'(bht_waddr), 32'(expAddr));
            checkOutput("bht_wdata", 32'(bht_wdata), 32'(expData));
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; id_req = 1'b0; id_idx = '0; id_data = '0;
        exe_req = 1'b0; exe_idx = '0; exe_data = '0;

        // Reset, then the full clearing sweep
        applyStimulus(1, 1, 0, 6'd0, 20'h0, 0, 6'd0, 20'h0);
        applyStimulus(1, 1, 0, 6'd0, 20'h0, 0, 6'd0, 20'h0);
        checkOutput("rstBusy", 32'(init_busy), 32'd1);
        checkOutput("rstWe", 32'(bht_we), 32'd0);
        checkOutput("rstDrop", 32'(drop_cnt), 32'd0);
        okCnt = 0;
        for (int i = 0; i < 64; i++) begin
            applyStimulus(0, 1, 0, 6'd0, 20'h0, 0, 6'd0, 20'h0);
            if (bht_we === 1'b1 && bht_waddr === 6'(i) && bht_wdata === 20'h0 && init_busy === 1'b1)
                okCnt++;
        end
        checkOutput("initSweep", 32'(okCnt), 32'd64);
        applyStimulus(0, 1, 0, 6'd0, 20'h0, 0, 6'd0, 20'h0);
        checkOutput("busyFall", 32'(init_busy), 32'd0);
        checkOutput("runIdleWe", 32'(bht_we), 32'd0);

        // ID priority while two EXE updates queue up
        applyStimulus(0, 1, 1, 6'd20, 20'hAAAAA, 1, 6'd5, 20'h00005);
        checkOutput("ack1", 32'(id_ack), 32'd1);
        applyStimulus(0, 1, 1, 6'd20, 20'hAAAAA, 1, 6'd9, 20'h00009);
        checkOutput("ack2", 32'(id_ack), 32'd1);
        applyStimulus(0, 1, 1, 6'd20, 20'hAAAAA, 0, 6'd0, 20'h0);
        checkOutput("ack3", 32'(id_ack), 32'd1);
        checkOutput("fullAfter2", 32'(exe_full), 32'd1);
        applyStimulus(0, 0, 1, 6'd20, 20'hAAAAA, 1, 6'd33, 20'h00033);
        checkOutput("enOffWe", 32'(bht_we), 32'd0);
        checkOutput("enOffAck", 32'(id_ack), 32'd0);
        applyStimulus(0, 1, 0, 6'd0, 20'h0, 0, 6'd0, 20'h0);
        checkOutput("drainAddr5", 32'(bht_waddr), 32'd5);
        checkOutput("drainData5", 32'(bht_wdata), 32'h00005);
        applyStimulus(0, 1, 0, 6'd0, 20'h0, 0, 6'd0, 20'h0);
        checkOutput("drainAddr9", 32'(bht_waddr), 32'd9);
        applyStimulus(0, 1, 0, 6'd0, 20'h0, 0, 6'd0, 20'h0);
        checkOutput("drainEmpty", 32'(bht_we), 32'd0);

        // Coalescing onto the tail
        applyStimulus(0, 1, 1, 6'd20, 20'hBBBBB, 1, 6'd9, 20'h00099);
        applyStimulus(0, 1, 1, 6'd20, 20'hBBBBB, 1, 6'd9, 20'h12345);
        applyStimulus(0, 1, 1, 6'd20, 20'hBBBBB, 0, 6'd0, 20'h0);
        checkOutput("coalesceNotFull", 32'(exe_full), 32'd0);
        applyStimulus(0, 1, 0, 6'd0, 20'h0, 0, 6'd0, 20'h0);
        checkOutput("coalesceAddr", 32'(bht_waddr), 32'd9);
        checkOutput("coalesceData", 32'(bht_wdata), 32'h12345);
        applyStimulus(0, 1, 0, 6'd0, 20'h0, 0, 6'd0, 20'h0);
        checkOutput("coalesceOnce", 32'(bht_we), 32'd0);

        // ID allocation supersedes queued and same-cycle updates to its index
        applyStimulus(0, 1, 1, 6'd20, 20'hBBBBB, 1, 6'd7, 20'h00077);
        applyStimulus(0, 1, 1, 6'd7, 20'hDDDDD, 1, 6'd7, 20'hEEEEE);
        checkOutput("supAddr", 32'(bht_waddr), 32'd7);
        checkOutput("supData", 32'(bht_wdata), 32'hDDDDD);
        applyStimulus(0, 1, 0, 6'd0, 20'h0, 0, 6'd0, 20'h0);
        checkOutput("supEmpty", 32'(bht_we), 32'd0);
        checkOutput("supNoDrop", 32'(drop_cnt), 32'd0);

        // Direct bypass with an empty queue
        applyStimulus(0, 1, 0, 6'd0, 20'h0, 1, 6'd44, 20'h00044);
        checkOutput("bypassAddr", 32'(bht_waddr), 32'd44);
        checkOutput("bypassData", 32'(bht_wdata), 32'h00044);
        applyStimulus(0, 1, 0, 6'd0, 20'h0, 0, 6'd0, 20'h0);
        checkOutput("bypassNoQueue", 32'(bht_we), 32'd0);

        // Drops when full, saturation, then pop-before-push
        applyStimulus(0, 1, 1, 6'd20, 20'hAAAAA, 1, 6'd5, 20'h00005);
        applyStimulus(0, 1, 1, 6'd20, 20'hAAAAA, 1, 6'd9, 20'h00009);
        applyStimulus(0, 1, 1, 6'd20, 20'hAAAAA, 1, 6'd12, 20'h0000C);
        applyStimulus(0, 1, 1, 6'd20, 20'hAAAAA, 0, 6'd0, 20'h0);
        checkOutput("drop1", 32'(drop_cnt), 32'd1);
        for (int i = 0; i < 300; i++)
            applyStimulus(0, 1, 1, 6'd20, 20'hAAAAA, 1, 6'd12, 20'h0000C);
        applyStimulus(0, 1, 1, 6'd20, 20'hAAAAA, 0, 6'd0, 20'h0);
        checkOutput("dropSat", 32'(drop_cnt), 32'd255);
        applyStimulus(0, 1, 0, 6'd0, 20'h0, 1, 6'd12, 20'h0000C);
        checkOutput("popPushAddr", 32'(bht_waddr), 32'd5);
        applyStimulus(0, 1, 0, 6'd0, 20'h0, 0, 6'd0, 20'h0);
        checkOutput("popPushFull", 32'(exe_full), 32'd1);
        checkOutput("popPushAddr9", 32'(bht_waddr), 32'd9);
        applyStimulus(0, 1, 0, 6'd0, 20'h0, 0, 6'd0, 20'h0);
        checkOutput("popPushAddr12", 32'(bht_waddr), 32'd12);

        // Reset mid-RUN with a queued entry, then again mid-sweep at 30
        applyStimulus(0, 1, 1, 6'd20, 20'hAAAAA, 1, 6'd3, 20'h00003);
        applyStimulus(1, 1, 0, 6'd0, 20'h0, 0, 6'd0, 20'h0);
        checkOutput("rstRunFull", 32'(exe_full), 32'd0);
        for (int i = 0; i < 15; i++) applyStimulus(0, 1, 0, 6'd0, 20'h0, 0, 6'd0, 20'h0);
        applyStimulus(0, 0, 0, 6'd0, 20'h0, 1, 6'd1, 20'h1);
        checkOutput("initEnOff", 32'(bht_we), 32'd0);
        for (int i = 0; i < 15; i++) applyStimulus(0, 1, 0, 6'd0, 20'h0, 0, 6'd0, 20'h0);
        checkOutput("sweep29", 32'(bht_waddr), 32'd29);
        applyStimulus(1, 1, 0, 6'd0, 20'h0, 0, 6'd0, 20'h0);
        applyStimulus(0, 1, 0, 6'd0, 20'h0, 0, 6'd0, 20'h0);
        checkOutput("restartAddr", 32'(bht_waddr), 32'd0);
        checkOutput("restartWe", 32'(bht_we), 32'd1);
        for (int i = 0; i < 63; i++) applyStimulus(0, 1, 0, 6'd0, 20'h0, 0, 6'd0, 20'h0);
        applyStimulus(0, 1, 0, 6'd0, 20'h0, 0, 6'd0, 20'h0);
        checkOutput("restartBusy", 32'(init_busy), 32'd0);
        checkOutput("restartQueueEmpty", 32'(bht_we), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
